// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and default widths for mem_port_arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IF) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between IF and DM requests.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise DM always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  owner_t last_owner,
  output logic   grant_vld,
  output owner_t grant_own
);

  always_comb begin
    grant_vld = if_req | dm_req;
    grant_own = dm_req ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
    // On a tie, serve whichever port did not get the previous grant.
    if (if_req && dm_req) begin
      grant_own = other_owner(last_owner);
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  owner_t unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF and MEM stages: IDLE/BUSY/RESP sequencer
// with timeout abort. Define MEM_ARB_RR_EN for round-robin tie-break (default: DM priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  owner_t           owner;
  owner_t           last_owner;
  logic             grant_vld;
  owner_t           grant_own;
  logic             do_grant, do_done, do_tmo;
  logic [CNT_W-1:0] tmo_cnt;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner),
    .grant_vld  (grant_vld),
    .grant_own  (grant_own)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_IF;
    end else if (do_grant) begin
      last_owner <= grant_own;
    end
  end
`else
  assign last_owner = OWN_DM;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_tmo    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          state_nxt = ST_BUSY;
          do_grant  = 1'b1;
        end
      end
      ST_BUSY: begin
        // A ready arriving on the last allowed cycle still counts as success.
        if (mem_ready) begin
          state_nxt = ST_RESP;
          do_done   = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_RESP;
          do_tmo    = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_IF;
      tmo_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (do_grant) begin
        owner    <= grant_own;
        tmo_cnt  <= '0;
        mem_en   <= 1'b1;
        if (grant_own == OWN_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (state == ST_BUSY && !mem_ready) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (do_done || do_tmo) begin
        mem_en <= 1'b0;
        if (do_tmo) begin
          err <= 1'b1;
        end
        // Aborted reads return zero; stores leave rdata untouched.
        if (owner == OWN_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= do_done ? mem_rdata : '0;
        end else begin
          dm_ack <= 1'b1;
          if (!mem_we) begin
            dm_rdata <= do_done ? mem_rdata : '0;
          end
        end
      end
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences, random vs. model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          stall_if;
  logic          stall_mem;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural memory: contents plus a per-transaction wait count.
  logic [31:0] mem_store [logic [31:0]];
  int busy_cnt = 0;
  int mem_wait = 0;
  int next_wait = 0;
  bit rand_wait = 1'b0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : mem_init(a);
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return TMO + 3;
    if (r == 1) return TMO - 1;
    if (r == 2) return TMO;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic respond();
    if (mem_en) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        mem_wait = next_wait;
        if (rand_wait) next_wait = pick_wait();
      end
      if (busy_cnt > mem_wait) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_store[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_rd(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      busy_cnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    respond();
  endtask

  task automatic reset_dut();
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_dm_ack"}, dm_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_dm_rdata"}, dm_rdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Tie-break rule taken straight from the arbitration policy.
  function automatic bit pick_dm(input bit ifr, input bit dmr, input bit last_dm);
    if (!(ifr && dmr)) return dmr;
`ifdef MEM_ARB_RR_EN
    return !last_dm;
`else
    return 1'b1;
`endif
  endfunction

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr;
    logic        dmw;
    logic [31:0] dma;
    logic [31:0] dmd;
    int          wt;
    bit          do_pre;
    logic [31:0] pre;
    bit          exp_dm;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic        exp_we;
  } vec_t;

  vec_t vecs[7];

  // Random-phase reference model state.
  bit          m_act, m_dm, m_tmo, m_wr, m_last_dm;
  int          m_g, m_ack, m_free;
  logic [31:0] m_rd, m_addr;
  logic [31:0] e_if_rd, e_dm_rd;
  bit          e_err;
  logic [31:0] shadow [logic [31:0]];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int start, lat, en_cnt, k;
    bit got, addr_ok, seen_we;
    logic [31:0] exp_addr;
    bit ord [4];
    bit exp_ord [4];
    int first_ack, last_ack, n;
    bit exp_if_ack, exp_dm_ack, exp_en, gen_on, hold_if, hold_dm;

    vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         0,  1'b1, 32'h2002_0005, 1'b0, 2,  32'h2002_0005, 1'b0};
    vecs[1] = '{1'b1, 32'h48, 1'b1, 1'b1, 32'h10,  32'hDEAD_BEEF, 0,  1'b0, 32'h0,         1'b1, 2,  32'h0,         1'b1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h10,  32'h0,         0,  1'b0, 32'h0,         1'b1, 2,  32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,         4,  1'b1, 32'hCAFE_0001, 1'b1, 6,  32'hCAFE_0001, 1'b0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h204, 32'h0,         14, 1'b1, 32'h0BAD_F00D, 1'b1, 16, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0,         2,  1'b1, 32'h1357_9BDF, 1'b0, 4,  32'h1357_9BDF, 1'b0};
    vecs[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h208, 32'h0123_4567, 1,  1'b0, 32'h0,         1'b1, 3,  32'h0BAD_F00D, 1'b1};

    reset_dut();
    chk_all_zero("rst");

    // ---- vector table ----
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      exp_addr = v.exp_dm ? v.dma : v.ifa;
      if (v.do_pre) mem_store[exp_addr] = v.pre;
      next_wait = v.wt;
      if_req = v.ifr; if_addr = v.ifa;
      dm_req = v.dmr; dm_we = v.dmw; dm_addr = v.dma; dm_wdata = v.dmd;
      #1;
      chk($sformatf("v%0d_stall_if_c0", i), stall_if, v.ifr);
      chk($sformatf("v%0d_stall_mem_c0", i), stall_mem, v.dmr);
      start = cyc; en_cnt = 0; addr_ok = 1'b1; got = 1'b0; seen_we = 1'b0;
      k = 0;
      while (k < 40 && !got) begin
        tick();
        if (mem_en) begin
          en_cnt++;
          if (mem_addr !== exp_addr) addr_ok = 1'b0;
          seen_we = mem_we;
        end
        if (if_ack || dm_ack) got = 1'b1;
        k++;
      end
      lat = got ? cyc - start : -1;
      chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
      chk($sformatf("v%0d_dm_ack", i), dm_ack, v.exp_dm);
      chk($sformatf("v%0d_if_ack", i), if_ack, !v.exp_dm);
      chk($sformatf("v%0d_rdata", i), v.exp_dm ? dm_rdata : if_rdata, v.exp_rd);
      chk($sformatf("v%0d_stall_at_ack", i), v.exp_dm ? stall_mem : stall_if, 0);
      chk($sformatf("v%0d_en_cycles", i), en_cnt, v.exp_lat - 1);
      chk($sformatf("v%0d_addr_stable", i), addr_ok, 1);
      chk($sformatf("v%0d_mem_we", i), seen_we, v.exp_we);
      chk($sformatf("v%0d_err", i), err, 0);
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      tick();
      tick();
    end
    chk("store_written", mem_store[32'h208], 32'h0123_4567);

    // ---- both request, DM store first, IF three cycles later ----
    reset_dut();
    next_wait = 0;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("both_c1_mem_en", mem_en, 1);
    chk("both_c1_mem_we", mem_we, 1);
    chk("both_c1_mem_addr", mem_addr, 32'h10);
    chk("both_c1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("both_c2_dm_ack", dm_ack, 1);
    chk("both_c2_if_ack", if_ack, 0);
    chk("both_c2_stall_if", stall_if, 1);
    chk("both_c2_dm_rdata_kept", dm_rdata, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("both_c3_if_ack", if_ack, 0);
    tick();
    chk("both_c4_if_ack", if_ack, 0);
    tick();
    chk("both_c5_if_ack", if_ack, 1);
    chk("both_c5_if_rdata", if_rdata, mem_rd(32'h80));
    if_req = 1'b0;
    tick();

    // ---- four back-to-back grants with both requests held ----
    reset_dut();
    next_wait = 0;
    if_req = 1'b1; if_addr = 32'h64;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
`ifdef MEM_ARB_RR_EN
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    start = cyc; n = 0; first_ack = -1; last_ack = -1;
    for (int j = 0; j < 40 && n < 4; j++) begin
      tick();
      if (if_ack || dm_ack) begin
        ord[n] = dm_ack;
        if (n == 0) first_ack = cyc - start;
        last_ack = cyc - start;
        n++;
      end
    end
    chk("order_count", n, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("order_%0d_dm", j), ord[j], exp_ord[j]);
    chk("order_first_ack", first_ack, 2);
    chk("order_last_ack", last_ack, 11);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    tick();

    // ---- hung memory: timeout abort ----
    chk("pre_tmo_dm_rdata", dm_rdata, mem_init(32'h60));
    next_wait = 1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    start = cyc; got = 1'b0;
    for (int j = 0; j < 30 && !got; j++) begin
      tick();
      if (cyc - start == 15) begin
        chk("tmo_c15_mem_en", mem_en, 1);
        chk("tmo_c15_err", err, 0);
      end
      if (if_ack || dm_ack) got = 1'b1;
    end
    chk("tmo_latency", got ? cyc - start : -1, 16);
    chk("tmo_dm_ack", dm_ack, 1);
    chk("tmo_err", err, 1);
    chk("tmo_dm_rdata", dm_rdata, 0);
    chk("tmo_mem_en_dropped", mem_en, 0);
    dm_req = 1'b0;
    next_wait = 0;
    tick(); tick(); tick();
    chk("tmo_err_sticky", err, 1);

    // ---- reset in the second BUSY cycle ----
    next_wait = 5;
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    tick();
    chk("rstmid_c2_mem_en", mem_en, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("rstmid");
    reset = 1'b0;
    next_wait = 0;
    tick();
    chk("rstmid_c4_if_ack", if_ack, 0);
    chk("rstmid_c4_mem_en", mem_en, 1);
    tick();
    chk("rstmid_c5_if_ack", if_ack, 1);
    chk("rstmid_c5_if_rdata", if_rdata, 32'h1357_9BDF);
    if_req = 1'b0;
    tick();

    // ---- randomized traffic against the transaction model ----
    reset_dut();
    rand_wait = 1'b1;
    next_wait = pick_wait();
    m_act = 1'b0; m_last_dm = 1'b0; m_free = 0;
    e_if_rd = '0; e_dm_rd = '0; e_err = 1'b0;
    hold_if = 1'b0; hold_dm = 1'b0;
    for (int c = 0; c < 700; c++) begin
      tick();
      gen_on = (c < 640);
      exp_if_ack = m_act && !m_dm && (cyc == m_ack);
      exp_dm_ack = m_act && m_dm && (cyc == m_ack);
      exp_en = m_act && (cyc > m_g) && (cyc < m_ack);
      if (m_act && cyc == m_ack) begin
        if (!m_wr) begin
          if (m_dm) e_dm_rd = m_tmo ? 32'h0 : m_rd;
          else      e_if_rd = m_tmo ? 32'h0 : m_rd;
        end
        if (m_tmo) e_err = 1'b1;
        m_act = 1'b0;
      end
      chk("rnd_if_ack", if_ack, exp_if_ack);
      chk("rnd_dm_ack", dm_ack, exp_dm_ack);
      chk("rnd_mem_en", mem_en, exp_en);
      if (exp_en) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", mem_we, m_wr);
      end
      chk("rnd_if_rdata", if_rdata, e_if_rd);
      chk("rnd_dm_rdata", dm_rdata, e_dm_rd);
      chk("rnd_err", err, e_err);

      if (exp_if_ack) hold_if = 1'b0;
      if (exp_dm_ack) hold_dm = 1'b0;
      if (!hold_if) begin
        hold_if = gen_on && ($urandom_range(0, 2) != 0);
        if_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      end
      if (!hold_dm) begin
        hold_dm = gen_on && ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) != 0;
        dm_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        dm_wdata = $urandom;
      end
      if_req = hold_if;
      dm_req = hold_dm;

      if (cyc >= m_free && (if_req || dm_req)) begin
        m_dm   = pick_dm(if_req, dm_req, m_last_dm);
        m_last_dm = m_dm;
        m_g    = cyc;
        m_tmo  = next_wait >= TMO;
        m_ack  = m_tmo ? cyc + 1 + TMO : cyc + 2 + next_wait;
        m_free = m_ack + 1;
        m_addr = m_dm ? dm_addr : if_addr;
        m_wr   = m_dm && dm_we;
        if (m_wr) begin
          if (!m_tmo) shadow[m_addr] = dm_wdata;
        end else begin
          m_rd = shadow.exists(m_addr) ? shadow[m_addr] : mem_init(m_addr);
        end
        m_act = 1'b1;
      end
    end
    chk("rnd_drained", m_act, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
